multicycle_controller: RTL

- Main control FSM for the multi-cycle RV32I datapath: the producer side of the ALU_op interface consumed by the ALU decoder, plus all datapath select/enable strobes.
- Sequences each instruction through FETCH/DECODE/execute/writeback states from the latched opcode.
- Sits between the instruction register and the datapath. ALU_func generation stays in the ALU decoder.

---
 rtl/multicycle_controller_if.sv | 37 +++
 rtl/multicycle_controller.sv | 127 ++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction-field inputs and datapath strobes of the multicycle controller.
// With ILLEGAL_TRAP_EN defined, the bundle also carries the illegal-opcode flag.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] f3;
    logic       zero;
    logic       lt;
    logic       PC_write;
    logic       adr_src;
    logic       mem_write;
    logic       IR_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] ALU_src_A;
    logic [1:0] ALU_src_B;
    logic [1:0] ALU_op;
    logic [2:0] imm_src;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal;
`endif
    modport master (
        input  op, f3, zero, lt,
        output PC_write, adr_src, mem_write, IR_write, reg_write,
               result_src, ALU_src_A, ALU_src_B, ALU_op, imm_src
`ifdef ILLEGAL_TRAP_EN
        , output illegal
`endif
    );
    modport slave (
        output op, f3, zero, lt,
        input  PC_write, adr_src, mem_write, IR_write, reg_write,
               result_src, ALU_src_A, ALU_src_B, ALU_op, imm_src
`ifdef ILLEGAL_TRAP_EN
        , input illegal
`endif
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: main RV32I multi-cycle control FSM driving datapath selects and strobes.
// ILLEGAL_TRAP_EN adds a HALT state and the illegal flag for unknown opcodes.
module multicycle_controller (
    input logic clk,
    input logic rst,
    multicycle_controller_if.master bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I,
        ALU_WB, BRANCH, JAL, JALR, LUI
`ifdef ILLEGAL_TRAP_EN
        , HALT
`endif
    } state_t;
    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
        logic [2:0] imm_src;
    } ctrl_t;
    // FETCH selects with every write strobe suppressed, shown while rst is high
    localparam ctrl_t RST_CTRL = ctrl_t'(16'b0_0_0_0_0_10_00_10_00_000);
    function automatic ctrl_t ctrl_of(input state_t s, input logic [6:0] o);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:     begin c.pc_write = 1'b1; c.ir_write = 1'b1; c.src_b = 2'b10; c.result_src = 2'b10; end
            DECODE:    begin c.src_a = 2'b01; c.src_b = 2'b01; end
            MEM_ADR:   begin c.src_a = 2'b10; c.src_b = 2'b01; c.imm_src = (o == OP_STORE) ? 3'b001 : 3'b000; end
            MEM_READ:  c.adr_src = 1'b1;
            MEM_WB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
            MEM_WRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
            EXEC_R:    begin c.src_a = 2'b10; c.alu_op = 2'b10; end
            EXEC_I:    begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu_op = 2'b11; end
            ALU_WB:    c.reg_write = 1'b1;
            BRANCH:    begin c.src_a = 2'b10; c.alu_op = 2'b01; end
            JALR:      begin c.src_a = 2'b10; c.src_b = 2'b01; end
            JAL:       begin c.pc_write = 1'b1; c.src_a = 2'b01; c.src_b = 2'b10; end
            LUI:       begin c.imm_src = 3'b100; c.result_src = 2'b11; c.reg_write = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction
    state_t state, nxt;
    ctrl_t  q, c;
    logic   taken;
    always_comb begin
        nxt = FETCH;
        case (state)
            FETCH:   nxt = DECODE;
            DECODE:  nxt = (bus.op == OP_LOAD || bus.op == OP_STORE) ? MEM_ADR :
                           (bus.op == OP_R)      ? EXEC_R :
                           (bus.op == OP_I)      ? EXEC_I :
                           (bus.op == OP_BRANCH) ? BRANCH :
                           (bus.op == OP_JAL)    ? JAL :
                           (bus.op == OP_JALR)   ? JALR :
                           (bus.op == OP_LUI)    ? LUI :
`ifdef ILLEGAL_TRAP_EN
                           HALT;
`else
                           FETCH;
`endif
            MEM_ADR: nxt = (bus.op == OP_LOAD) ? MEM_READ : MEM_WRITE;
            MEM_READ: nxt = MEM_WB;
            EXEC_R, EXEC_I, JAL: nxt = ALU_WB;
            JALR:    nxt = JAL;
`ifdef ILLEGAL_TRAP_EN
            HALT:    nxt = HALT;
`endif
            default: nxt = FETCH;
        endcase
    end
    always_comb begin
        taken = (bus.f3 == 3'b000) ? bus.zero :
                (bus.f3 == 3'b001) ? !bus.zero :
                (bus.f3 == 3'b100) ? bus.lt :
                (bus.f3 == 3'b101) ? !bus.lt : 1'b0;
        c = q;
        // the instruction register loads on the FETCH edge, so DECODE's immediate type must follow op live
        if (state == DECODE) c.imm_src = (bus.op == OP_BRANCH) ? 3'b010 : (bus.op == OP_JAL) ? 3'b011 : 3'b000;
        if (state == BRANCH) c.pc_write = taken;
        if (rst) c = RST_CTRL;
    end
`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
    assign bus.illegal = illegal_q && !rst;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            q <= ctrl_of(FETCH, bus.op);
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state <= nxt;
            q <= ctrl_of(nxt, bus.op);
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= (nxt == HALT);
`endif
        end
    end
    assign bus.PC_write   = c.pc_write;
    assign bus.adr_src    = c.adr_src;
    assign bus.mem_write  = c.mem_write;
    assign bus.IR_write   = c.ir_write;
    assign bus.reg_write  = c.reg_write;
    assign bus.result_src = c.result_src;
    assign bus.ALU_src_A  = c.src_a;
    assign bus.ALU_src_B  = c.src_b;
    assign bus.ALU_op     = c.alu_op;
    assign bus.imm_src    = c.imm_src;
endmodule
